db_delete_rr_arbiter: RTL and testbench
=======================================

DB_DELETE_RR_ARBITER -- requirements
Module: db_delete_rr_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- CHNL_NUM, 4, number of requesting channels, legal range 2..8.
- HEAD_WIDTH, `MAX_DB_SLOT_NUM_LOG*2, width of the delete head.
- DATA_WIDTH, `PACKET_BUFFER_SLOT_WIDTH, width of a response beat.
- ARB_MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with the lowest index winning.
- IDX_W, clog2(CHNL_NUM), width of a channel index.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, clock.
- rst, in, 1, reset: asynchronous, active-high.
- chnl_req_valid, in, CHNL_NUM, per-channel delete request valid.
- chnl_req_head, in, CHNL_NUM*HEAD_WIDTH, per-channel head; channel i occupies bits [i*HEAD_WIDTH +: HEAD_WIDTH].
- chnl_req_ready, out, CHNL_NUM, per-channel request ready.
- chnl_resp_valid, out, CHNL_NUM, per-channel response valid.
- chnl_resp_start, out, CHNL_NUM, per-channel first-beat flag.
- chnl_resp_last, out, CHNL_NUM, per-channel last-beat flag.
- chnl_resp_data, out, CHNL_NUM*DATA_WIDTH, per-channel response data.
- chnl_resp_ready, in, CHNL_NUM, per-channel response ready.
- delete_req_valid, out, 1, request valid to the dynamic buffer.
- delete_req_head, out, HEAD_WIDTH, forwarded head.
- delete_req_ready, in, 1, dynamic buffer accepts the request.
- delete_resp_valid, in, 1, response valid from the dynamic buffer.
- delete_resp_start, in, 1, response first-beat flag.
- delete_resp_last, in, 1, response last-beat flag.
- delete_resp_data, in, DATA_WIDTH, response data.
- delete_resp_ready, out, 1, response ready to the dynamic buffer.
- grant_idx, out, IDX_W, currently owning channel.
- busy, out, 1, high while state is not IDLE.

Function
REQ-003 The block SHALL implement an FSM with states IDLE, REQ and RESP, using a registered state.
- IDLE -> REQ when any chnl_req_valid bit is set; the winning index is latched into grant_idx.
- REQ -> RESP on delete_req_valid && delete_req_ready.
- RESP -> IDLE on delete_resp_valid && delete_resp_last && delete_resp_ready.
- All other cases hold the current state.

REQ-004 Round-robin (ARB_MODE=0) SHALL search from (last_grant+1) mod CHNL_NUM upward, wrapping, and select the first set valid bit.

REQ-005 Fixed priority (ARB_MODE=1) SHALL select the lowest set index; last_grant is ignored.

REQ-006 last_grant SHALL update to grant_idx only on the RESP->IDLE transition; it SHALL NOT update on request acceptance.

REQ-007 In REQ, the block SHALL drive:
- delete_req_valid = chnl_req_valid[grant_idx].
- delete_req_head = the head of grant_idx.
- chnl_req_ready[grant_idx] = delete_req_ready, with all other ready bits 0.
- delete_resp_ready = 0.

REQ-008 In RESP, the block SHALL drive:
- chnl_resp_valid/start/last/data of grant_idx = the delete_resp_* inputs.
- delete_resp_ready = chnl_resp_ready[grant_idx].
- All non-granted response outputs = 0.
- All chnl_req_ready bits = 0.

REQ-009 In IDLE, all req_ready, resp_valid/start/last/data, delete_req_valid, delete_req_head and delete_resp_ready outputs SHALL be 0.

REQ-010 Arbitration latency SHALL be one cycle: a valid sampled in IDLE produces delete_req_valid in the following cycle. The minimum gap between transactions SHALL be one IDLE cycle.

REQ-011 A granted channel that drops valid while in REQ SHALL keep ownership; the block SHALL wait in REQ until valid returns and the handshake completes. Channels SHALL hold valid until ready.

REQ-012 Requests from non-granted channels SHALL be ignored and SHALL NOT be lost. They remain pending until won in a later IDLE cycle.

REQ-013 A single-beat response (start=last=1) SHALL complete RESP in one handshake cycle.

REQ-014 Back-pressure: while chnl_resp_ready[grant_idx]=0, delete_resp_ready SHALL be 0 and the state SHALL hold.

REQ-015 When all channels request continuously in ARB_MODE=0, grants SHALL rotate 0,1,...,CHNL_NUM-1,0 with no channel skipped.

REQ-016 Non-power-of-two CHNL_NUM SHALL wrap correctly; grant_idx SHALL never exceed CHNL_NUM-1.

Reset
REQ-017 On rst assertion, the block SHALL immediately force:
- state = IDLE.
- grant_idx = 0.
- last_grant = CHNL_NUM-1, so that channel 0 wins first.
- busy = 0.
- All outputs 0.

REQ-018 Reset asserted mid-transaction SHALL abandon the transaction with no further handshake outputs. Recovery of the dynamic buffer is upstream's responsibility.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset release with CHNL_NUM=4 and all valids=4'b1111, each response 1 beat -> grant order 0,1,2,3,0.
- Only chnl 2 valid, head=0x1A5, 3-beat response -> delete_req_head=0x1A5; beats appear only on chnl 2 with start on beat 1 and last on beat 3; then IDLE.
- ARB_MODE=1 with valids 4'b1010 held -> chnl 1 granted repeatedly; chnl 3 is never granted.
- In RESP, hold chnl_resp_ready low for 5 cycles -> delete_resp_ready=0, state held, no beat lost.
- rst pulsed while in RESP -> next cycle all outputs 0, busy=0; next grant goes to chnl 0.
- CHNL_NUM=3 with all valid -> grants 0,1,2,0; grant_idx never equals 3.

Source files
------------

// File: rtl/db_delete_rr_arbiter.sv
// db_delete_rr_arbiter
// Shares the single dynamic-buffer delete port among CHNL_NUM channels.
// A winner is picked in IDLE (round-robin or fixed priority) and owns the
// port until its request is accepted and its last response beat is taken.
`ifndef MAX_DB_SLOT_NUM_LOG
`define MAX_DB_SLOT_NUM_LOG 5
`endif
`ifndef PACKET_BUFFER_SLOT_WIDTH
`define PACKET_BUFFER_SLOT_WIDTH 64
`endif

module db_delete_rr_arbiter #(
    parameter int CHNL_NUM   = 4,
    parameter int HEAD_WIDTH = `MAX_DB_SLOT_NUM_LOG*2,
    parameter int DATA_WIDTH = `PACKET_BUFFER_SLOT_WIDTH,
    parameter int ARB_MODE   = 0,
    parameter int IDX_W      = $clog2(CHNL_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHNL_NUM-1:0]            chnl_req_valid,
    input  logic [CHNL_NUM*HEAD_WIDTH-1:0] chnl_req_head,
    output logic [CHNL_NUM-1:0]            chnl_req_ready,
    output logic [CHNL_NUM-1:0]            chnl_resp_valid,
    output logic [CHNL_NUM-1:0]            chnl_resp_start,
    output logic [CHNL_NUM-1:0]            chnl_resp_last,
    output logic [CHNL_NUM*DATA_WIDTH-1:0] chnl_resp_data,
    input  logic [CHNL_NUM-1:0]            chnl_resp_ready,
    output logic                           delete_req_valid,
    output logic [HEAD_WIDTH-1:0]          delete_req_head,
    input  logic                           delete_req_ready,
    input  logic                           delete_resp_valid,
    input  logic                           delete_resp_start,
    input  logic                           delete_resp_last,
    input  logic [DATA_WIDTH-1:0]          delete_resp_data,
    output logic                           delete_resp_ready,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [IDX_W-1:0] cand [CHNL_NUM];

    // Search order: slot k is the k-th channel examined. Round-robin starts
    // one past the last completed owner and wraps; the sum never reaches
    // 2*CHNL_NUM so a single conditional subtract handles non-power-of-two.
    for (genvar k = 0; k < CHNL_NUM; k++) begin : g_cand
        logic [IDX_W+1:0] sum;
        assign sum = {2'b00, last_grant} + (IDX_W+2)'(k + 1);
        assign cand[k] = (ARB_MODE == 1) ? IDX_W'(k) :
                         (sum >= (IDX_W+2)'(CHNL_NUM)) ? IDX_W'(sum - (IDX_W+2)'(CHNL_NUM)) :
                                                         IDX_W'(sum);
    end

    // First requesting channel in search order
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < CHNL_NUM; k++) begin
            if (!found && chnl_req_valid[cand[k]]) begin
                pick  = cand[k];
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Owner latched when leaving IDLE; history advances only on completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_idx  <= '0;
            last_grant <= IDX_W'(CHNL_NUM - 1);
        end else begin
            if (state == IDLE && found)
                grant_idx <= pick;
            if (state == RESP && state_nxt == IDLE)
                last_grant <= grant_idx;
        end
    end

    // Next state and steering of the owner's handshakes
    always_comb begin
        state_nxt         = state;
        chnl_req_ready    = '0;
        chnl_resp_valid   = '0;
        chnl_resp_start   = '0;
        chnl_resp_last    = '0;
        chnl_resp_data    = '0;
        delete_req_valid  = 1'b0;
        delete_req_head   = '0;
        delete_resp_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) state_nxt = REQ;
            end
            REQ: begin
                delete_req_valid          = chnl_req_valid[grant_idx];
                delete_req_head           = chnl_req_head[grant_idx*HEAD_WIDTH +: HEAD_WIDTH];
                chnl_req_ready[grant_idx] = delete_req_ready;
                if (delete_req_valid && delete_req_ready) state_nxt = RESP;
            end
            RESP: begin
                chnl_resp_valid[grant_idx] = delete_resp_valid;
                chnl_resp_start[grant_idx] = delete_resp_start;
                chnl_resp_last[grant_idx]  = delete_resp_last;
                chnl_resp_data[grant_idx*DATA_WIDTH +: DATA_WIDTH] = delete_resp_data;
                delete_resp_ready          = chnl_resp_ready[grant_idx];
                if (delete_resp_valid && delete_resp_last && delete_resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_db_delete_rr_arbiter.sv
// Bench for db_delete_rr_arbiter: three configurations (4ch round-robin,
// 4ch fixed priority, 3ch round-robin) run the same phased random traffic.
// Each has a transaction-level model, a scoreboard of expected requests and
// beats, and a per-cycle check of every output against the model.
module tb_db_delete_rr_arbiter;

    localparam int HW = 10;
    localparam int DW = 16;

    localparam int PH_DRAIN = 0;
    localparam int PH_ALL   = 1;
    localparam int PH_C2    = 2;
    localparam int PH_1010  = 3;
    localparam int PH_BP    = 4;
    localparam int PH_RND   = 5;
    localparam int PH_RST   = 6;

    typedef struct {
        int          chan;
        logic [15:0] head;
    } req_t;

    typedef struct {
        int          chan;
        logic        start;
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic       clk;
    logic       rst;
    int         phase;
    int         req_pct;
    int         rdy_pct;
    int         fixed_beats;
    logic [7:0] req_mask;
    bit         fixed_head;
    bit         hold_resp;
    bit         done;
    int         n_checks;
    int         n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int inst, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", inst, name, act, exp, $time);
        end
    endtask

    // Reference arbitration: plain rotation / lowest index over the valid set
    function automatic int pick(input logic [7:0] v, input int last, input int n, input int mode);
        if (mode == 1) begin
            for (int i = 0; i < n; i++) if (v[i]) return i;
        end else begin
            for (int k = 1; k <= n; k++) if (v[(last + k) % n]) return (last + k) % n;
        end
        return 0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int N    = (g == 2) ? 3 : 4;
        localparam int MODE = (g == 1) ? 1 : 0;
        localparam int IW   = $clog2(N);

        logic [N-1:0]    req_valid, req_ready, resp_valid, resp_start, resp_last, resp_ready;
        logic [N*HW-1:0] req_head;
        logic [N*DW-1:0] resp_data;
        logic            dq_valid, dq_ready, dr_valid, dr_start, dr_last, dr_ready, bsy;
        logic [HW-1:0]   dq_head;
        logic [DW-1:0]   dr_data;
        logic [IW-1:0]   grant;

        db_delete_rr_arbiter #(
            .CHNL_NUM(N), .HEAD_WIDTH(HW), .DATA_WIDTH(DW), .ARB_MODE(MODE), .IDX_W(IW)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .chnl_req_valid    (req_valid),
            .chnl_req_head     (req_head),
            .chnl_req_ready    (req_ready),
            .chnl_resp_valid   (resp_valid),
            .chnl_resp_start   (resp_start),
            .chnl_resp_last    (resp_last),
            .chnl_resp_data    (resp_data),
            .chnl_resp_ready   (resp_ready),
            .delete_req_valid  (dq_valid),
            .delete_req_head   (dq_head),
            .delete_req_ready  (dq_ready),
            .delete_resp_valid (dr_valid),
            .delete_resp_start (dr_start),
            .delete_resp_last  (dr_last),
            .delete_resp_data  (dr_data),
            .delete_resp_ready (dr_ready),
            .grant_idx         (grant),
            .busy              (bsy)
        );

        // model: 0 = idle, 1 = request outstanding, 2 = response phase
        int    m_phase, m_chan, m_last;
        int    r_left, r_idx, stall_left, gcnt, seen_phase;
        bit    r_present;
        req_t  exp_req[$];
        beat_t exp_beat[$];

        task automatic model_reset();
            m_phase    = 0;
            m_chan     = 0;
            m_last     = N - 1;
            r_left     = 0;
            r_idx      = 0;
            r_present  = 0;
            stall_left = 0;
            gcnt       = 0;
            dr_valid   = 1'b0;
            exp_req.delete();
            exp_beat.delete();
        endtask

        // Apply the edge just taken (inputs still hold their pre-edge values),
        // then drive the next cycle's channel and buffer stimulus.
        task automatic step();
            req_t  r;
            beat_t b;
            case (m_phase)
                0: if (|req_valid) begin
                    m_chan  = pick(8'(req_valid), m_last, N, MODE);
                    r.chan  = m_chan;
                    r.head  = 16'(req_head[m_chan*HW +: HW]);
                    exp_req.push_back(r);
                    m_phase = 1;
                end
                1: if (req_valid[m_chan] && dq_ready) begin
                    req_valid[m_chan] = 1'b0;
                    m_phase    = 2;
                    r_left     = (fixed_beats != 0) ? fixed_beats : int'($urandom_range(1, 4));
                    r_idx      = 0;
                    r_present  = 0;
                    stall_left = (phase == PH_BP) ? 5 : 0;
                end
                2: if (dr_valid && resp_ready[m_chan]) begin
                    r_present = 0;
                    r_left--;
                    if (dr_last) begin
                        m_phase = 0;
                        m_last  = m_chan;
                    end
                end
                default: ;
            endcase
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && req_mask[i] && int'($urandom_range(0, 99)) < req_pct) begin
                    req_valid[i] = 1'b1;
                    req_head[i*HW +: HW] = fixed_head ? HW'(12'h1A5) : HW'($urandom);
                end
            end
            dq_ready = (int'($urandom_range(0, 99)) < rdy_pct);
            if (m_phase == 2 && r_left > 0 && !r_present && int'($urandom_range(0, 99)) < rdy_pct) begin
                r_present = 1;
                dr_start  = (r_idx == 0);
                dr_last   = (r_left == 1);
                dr_data   = DW'($urandom);
                r_idx++;
                b.chan  = m_chan;
                b.start = dr_start;
                b.last  = dr_last;
                b.data  = 32'(dr_data);
                exp_beat.push_back(b);
            end else if (!r_present) begin
                dr_start = 1'($urandom);
                dr_last  = 1'($urandom);
                dr_data  = DW'($urandom);
            end
            dr_valid = r_present;
            for (int i = 0; i < N; i++) resp_ready[i] = (int'($urandom_range(0, 99)) < rdy_pct);
            if (hold_resp || stall_left > 0) resp_ready = '0;
            if (stall_left > 0) stall_left--;
        endtask

        initial begin
            req_valid  = '0;
            req_head   = '0;
            resp_ready = '0;
            dq_ready   = 1'b0;
            dr_start   = 1'b0;
            dr_last    = 1'b0;
            dr_data    = '0;
            seen_phase = -1;
            model_reset();
            forever begin
                @(posedge clk);
                #1;
                if (!rst) step();
            end
        end

        initial forever begin
            @(posedge rst);
            model_reset();
        end

        // Monitor: per-cycle output check plus scoreboard pops on handshakes
        initial begin : mon
            logic [255:0] act, exp;
            logic [7:0]   e_rq, e_rv, e_rs, e_rl;
            logic [63:0]  e_rd;
            logic [15:0]  e_dqh;
            logic         e_dqv, e_drr;
            bit           fin;
            req_t         r;
            beat_t        b;
            fin = 0;
            forever begin
                @(negedge clk);
                if (phase != seen_phase) begin
                    seen_phase = phase;
                    gcnt       = 0;
                end
                e_rq = '0; e_rv = '0; e_rs = '0; e_rl = '0; e_rd = '0;
                e_dqv = 1'b0; e_dqh = '0; e_drr = 1'b0;
                if (m_phase == 1) begin
                    e_rq[m_chan] = dq_ready;
                    e_dqv        = req_valid[m_chan];
                    e_dqh        = 16'(req_head[m_chan*HW +: HW]);
                end
                if (m_phase == 2) begin
                    e_rv[m_chan] = dr_valid;
                    e_rs[m_chan] = dr_start;
                    e_rl[m_chan] = dr_last;
                    e_rd[m_chan*DW +: DW] = dr_data;
                    e_drr        = resp_ready[m_chan];
                end
                act = '0;
                exp = '0;
                act[118:0] = {bsy, 4'(grant), 8'(req_ready), dq_valid, 16'(dq_head), dr_ready,
                              8'(resp_valid), 8'(resp_start), 8'(resp_last), 64'(resp_data)};
                exp[118:0] = {(m_phase != 0), 4'(m_chan), e_rq, e_dqv, e_dqh, e_drr,
                              e_rv, e_rs, e_rl, e_rd};
                chk("outputs", g, act, exp);

                if (dq_valid && dq_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("req_unexpected", g, 256'(1), 256'(0));
                    end else begin
                        r = exp_req.pop_front();
                        chk("req_chan", g, 256'(grant), 256'(r.chan));
                        chk("req_head", g, 256'(dq_head), 256'(r.head));
                    end
                    if (phase == PH_ALL && gcnt < 5)
                        chk("rotation", g, 256'(grant), 256'((MODE == 1) ? 0 : gcnt % N));
                    if (phase == PH_C2) begin
                        chk("c2_grant", g, 256'(grant), 256'(2));
                        chk("c2_head", g, 256'(dq_head), 256'(12'h1A5));
                    end
                    if (phase == PH_1010)
                        chk("grant_1010", g, 256'(grant == 1 || (MODE == 0 && grant == 3)), 256'(1));
                    gcnt++;
                end

                for (int i = 0; i < N; i++) begin
                    if (resp_valid[i] && resp_ready[i]) begin
                        if (exp_beat.size() == 0) begin
                            chk("beat_unexpected", g, 256'(1), 256'(0));
                        end else begin
                            b = exp_beat.pop_front();
                            chk("beat", g, 256'({8'(i), resp_start[i], resp_last[i], 32'(resp_data[i*DW +: DW])}),
                                256'({8'(b.chan), b.start, b.last, b.data}));
                        end
                        if (phase == PH_C2) chk("c2_beat_chan", g, 256'(i), 256'(2));
                    end
                end

                if (done && !fin) begin
                    fin = 1;
                    chk("req_q_empty", g, 256'(exp_req.size()), 256'(0));
                    chk("beat_q_empty", g, 256'(exp_beat.size()), 256'(0));
                end
            end
        end
    end

    task automatic set_phase(input int ph, input int rp, input logic [7:0] mask,
                             input bit fh, input int fb, input int rdy);
        phase       = ph;
        req_pct     = rp;
        req_mask    = mask;
        fixed_head  = fh;
        fixed_beats = fb;
        rdy_pct     = rdy;
    endtask

    task automatic drain();
        set_phase(PH_DRAIN, 0, 8'hFF, 0, 0, 100);
        hold_resp = 0;
        repeat (80) @(posedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        done     = 0;
        hold_resp = 0;
        rst      = 1'b1;
        set_phase(PH_DRAIN, 0, 8'hFF, 0, 0, 100);
        repeat (3) @(posedge clk);

        // all channels requesting, single-beat responses, from reset
        set_phase(PH_ALL, 100, 8'hFF, 0, 1, 100);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        drain();

        // only channel 2, fixed head, three-beat responses
        set_phase(PH_C2, 100, 8'h04, 1, 3, 100);
        repeat (30) @(posedge clk);
        drain();

        // channels 1 and 3 held
        set_phase(PH_1010, 100, 8'h0A, 0, 0, 100);
        repeat (40) @(posedge clk);
        drain();

        // response back-pressure of five cycles on every transaction
        set_phase(PH_BP, 50, 8'hFF, 0, 0, 100);
        repeat (80) @(posedge clk);
        drain();

        // free-running random traffic and handshakes
        set_phase(PH_RND, 30, 8'hFF, 0, 0, 70);
        repeat (1500) @(posedge clk);
        drain();

        // park every configuration in RESP, then reset mid-transaction
        set_phase(PH_RST, 100, 8'hFF, 0, 0, 100);
        hold_resp = 1;
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        set_phase(PH_ALL, 100, 8'hFF, 0, 1, 100);
        hold_resp = 0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (40) @(posedge clk);
        drain();

        done = 1;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
